// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS systolic grid: weight load, skewed activation stream, done pulse.
// Optional weight reuse across jobs is enabled by defining SYSTOLIC_CTRL_WREUSE_EN.
module systolic_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int VEC_W   = 8,
  parameter int WADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VEC_W-1:0]   num_vectors,
`ifdef SYSTOLIC_CTRL_WREUSE_EN
  input  logic               keep_weights,
`endif
  output logic               busy,
  output logic               done,
  output logic               mux_ctrl,
  output logic               weight_WE,
  output logic               wt_rd_en,
  output logic [WADDR_W-1:0] wt_rd_addr,
  output logic               act_rd_en,
  output logic [VEC_W-1:0]   act_rd_addr,
  output logic [ROWS-1:0]    left_valid,
  output logic [COLS-1:0]    out_valid,
  output logic [1:0]         dbg_state
);

  // Wide enough for K + ROWS + COLS - 1 at max K without wrapping.
  localparam int TW = VEC_W + 1 + $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t            state, nxt_state;
  logic [TW-1:0]     t, nxt_t;
  logic [VEC_W-1:0]  k_q, nxt_k;
  logic [TW-1:0]     k_ext_q, nk_ext;
  logic              skip_load;

  logic               o_busy, o_done, o_mux, o_we, o_wt_en, o_act_en;
  logic [WADDR_W-1:0] o_wt_addr;
  logic [VEC_W-1:0]   o_act_addr;
  logic [ROWS-1:0]    o_left;
  logic [COLS-1:0]    o_out;

`ifdef SYSTOLIC_CTRL_WREUSE_EN
  logic w_loaded;
  assign skip_load = keep_weights && w_loaded;
`else
  assign skip_load = 1'b0;
`endif

  assign dbg_state = state;
  assign k_ext_q   = {{(TW-VEC_W){1'b0}}, k_q};
  assign nk_ext    = {{(TW-VEC_W){1'b0}}, nxt_k};

  always_comb begin
    nxt_state = state;
    nxt_t     = t;
    nxt_k     = k_q;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_k = num_vectors;
          nxt_t = '0;
          if (skip_load) nxt_state = (num_vectors == '0) ? DONE : COMPUTE;
          else           nxt_state = LOAD;
        end
      end
      LOAD: begin
        if (t == TW'(ROWS - 1)) begin
          nxt_t     = '0;
          nxt_state = (k_q == '0) ? DONE : COMPUTE;
        end else begin
          nxt_t = t + TW'(1);
        end
      end
      COMPUTE: begin
        if (t == k_ext_q + TW'(ROWS + COLS - 2)) begin
          nxt_t     = '0;
          nxt_state = DONE;
        end else begin
          nxt_t = t + TW'(1);
        end
      end
      default: begin
        nxt_t     = '0;
        nxt_state = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land registered in the cycle they describe.
  always_comb begin
    o_busy     = (nxt_state != IDLE);
    o_done     = (nxt_state == DONE);
    o_mux      = (nxt_state == LOAD);
    o_wt_en    = (nxt_state == LOAD);
    o_we       = (nxt_state == LOAD) && (nxt_t == TW'(ROWS - 1));
    o_wt_addr  = (nxt_state == LOAD) ? (WADDR_W'(ROWS - 1) - nxt_t[WADDR_W-1:0]) : '0;
    o_act_en   = (nxt_state == COMPUTE) && (nxt_t < nk_ext);
    o_act_addr = o_act_en ? nxt_t[VEC_W-1:0] : '0;
    o_left     = '0;
    o_out      = '0;
    for (int r = 0; r < ROWS; r++)
      o_left[r] = (nxt_state == COMPUTE) && (nxt_t >= TW'(r)) && (nxt_t < TW'(r) + nk_ext);
    for (int c = 0; c < COLS; c++)
      o_out[c] = (nxt_state == COMPUTE) && (nxt_t >= TW'(ROWS + c)) &&
                 (nxt_t < TW'(ROWS + c) + nk_ext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      t           <= '0;
      k_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mux_ctrl    <= 1'b0;
      weight_WE   <= 1'b0;
      wt_rd_en    <= 1'b0;
      wt_rd_addr  <= '0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      left_valid  <= '0;
      out_valid   <= '0;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
      w_loaded    <= 1'b0;
`endif
    end else begin
      state       <= nxt_state;
      t           <= nxt_t;
      k_q         <= nxt_k;
      busy        <= o_busy;
      done        <= o_done;
      mux_ctrl    <= o_mux;
      weight_WE   <= o_we;
      wt_rd_en    <= o_wt_en;
      wt_rd_addr  <= o_wt_addr;
      act_rd_en   <= o_act_en;
      act_rd_addr <= o_act_addr;
      left_valid  <= o_left;
      out_valid   <= o_out;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
      if (state == LOAD && t == TW'(ROWS - 1)) w_loaded <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (ROWS=COLS=4, VEC_W=8); job timing windows are hand-derived.
module tb_systolic_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_vectors;
  logic       keep_weights;
  logic       busy, done, mux_ctrl, weight_WE, wt_rd_en, act_rd_en;
  logic [3:0] wt_rd_addr;
  logic [7:0] act_rd_addr;
  logic [3:0] left_valid, out_valid;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  systolic_ctrl #(.ROWS(4), .COLS(4), .VEC_W(8), .WADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    .keep_weights(keep_weights),
`endif
    .busy(busy), .done(done), .mux_ctrl(mux_ctrl), .weight_WE(weight_WE),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr), .left_valid(left_valid), .out_valid(out_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inw(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk(tag, {busy, done, mux_ctrl, weight_WE, wt_rd_en, wt_rd_addr, act_rd_en,
              act_rd_addr, left_valid, out_valid}, 32'd0);
    chk({tag, "_state"}, dbg_state, 32'd0);
  endtask

  // Starts a job in the current cycle (cycle 0) and checks every output through done+2.
  task automatic job_check(input int k, input bit load, input int ign_a, input int ign_b);
    int lo, cs, ce, dc, dones;
    logic [3:0] elv, eov;
    logic [7:0] ea;
    lo = load ? 4 : 0;
    cs = lo + 1;
    ce = (k == 0) ? lo : lo + k + 7;
    dc = ce + 1;
    dones = 0;
    num_vectors = 8'(k);
    start = 1'b1;
    for (int i = 0; i < k; i++) exp_q.push_back(8'(i));
    for (int c = 1; c <= dc + 2; c++) begin
      tick;
      start = (c == ign_a) || (c == ign_b);
      chk("busy", busy, inw(c, 1, dc));
      chk("done", done, c == dc);
      chk("mux_ctrl", mux_ctrl, load && inw(c, 1, 4));
      chk("wt_rd_en", wt_rd_en, load && inw(c, 1, 4));
      chk("weight_we", weight_WE, load && c == 4);
      if (load && inw(c, 1, 4)) chk("wt_rd_addr", wt_rd_addr, 32'(4 - c));
      chk("act_rd_en", act_rd_en, inw(c, cs, cs + k - 1));
      if (act_rd_en) begin
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("act_rd_addr", act_rd_addr, ea);
      end
      for (int r = 0; r < 4; r++) elv[r] = inw(c, cs + r, cs + r + k - 1);
      for (int j = 0; j < 4; j++) eov[j] = inw(c, cs + 4 + j, cs + 4 + j + k - 1);
      chk("left_valid", left_valid, elv);
      chk("out_valid", out_valid, eov);
      if (done) dones++;
    end
    chk("done_count", dones, 32'd1);
    chk("act_q_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_vectors = '0;
    keep_weights = 1'b0;
    tick;
    tick;
    chk_idle_outs("reset");
    reset = 1'b0;

    // K=3 job with stray starts during LOAD and in the DONE cycle
    job_check(3, 1'b1, 3, 15);

    // K=0: LOAD then straight to DONE
    job_check(0, 1'b1, -1, -1);

    // reset at cycle 8 of a K=3 job, then a fresh job at cycle 10
    num_vectors = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      start = 1'b0;
      chk("midjob_done", done, 32'd0);
      chk("midjob_busy", busy, 32'd1);
    end
    reset = 1'b1;
    tick;
    chk_idle_outs("midjob_reset");
    reset = 1'b0;
    tick;
    chk_idle_outs("after_reset");
    job_check(3, 1'b1, -1, -1);

`ifdef SYSTOLIC_CTRL_WREUSE_EN
    keep_weights = 1'b0;
    job_check(1, 1'b1, -1, -1);
    keep_weights = 1'b1;
    job_check(2, 1'b0, -1, -1);
    job_check(0, 1'b0, -1, -1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    job_check(1, 1'b1, -1, -1);
    keep_weights = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
